// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a power-of-two FIFO, with optional parity and 1/2 stop bits
module uart_tx_fifo #(
    parameter int CLOCK_HZ   = 6000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          tx_enable,
    output logic                          serial_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CYCLES_PER_BIT = (CLOCK_HZ + BAUD / 2) / BAUD;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int TW   = $clog2(CYCLES_PER_BIT);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CYCLES_PER_BIT < 2) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop;

    state_t               state, state_n;
    logic [TW-1:0]        timer, timer_n;
    logic [2:0]           cnt, cnt_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 par, par_n;
    logic                 line_n;
    logic                 bit_done, last_data, last_stop, start_ok;

    assign head     = mem[rd_ptr];
    assign tx_ready = fifo_count < CNTW'(FIFO_DEPTH);
    assign push     = tx_valid && tx_ready;
    assign busy     = state != IDLE;

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
        end
    end

    // Transmit state, bit timer, shifter and the registered line
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            cnt       <= '0;
            sh        <= '0;
            par       <= 1'b0;
            serial_tx <= 1'b1;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            par       <= par_n;
            serial_tx <= line_n;
        end
    end

    // Next-state logic; a new frame loads from IDLE or straight out of the last stop bit
    always_comb begin
        bit_done  = timer == TW'(CYCLES_PER_BIT - 1);
        last_data = cnt == 3'(DATA_BITS - 1);
        last_stop = cnt == 3'(STOP_BITS - 1);
        start_ok  = fifo_count != '0 && tx_enable;
        state_n   = state;
        timer_n   = bit_done ? '0 : timer + 1'b1;
        cnt_n     = cnt;
        sh_n      = sh;
        par_n     = par;
        pop       = 1'b0;
        case (state)
            IDLE: timer_n = '0;
            START: if (bit_done) state_n = DATA;
            DATA: if (bit_done) begin
                sh_n    = sh >> 1;
                cnt_n   = last_data ? 3'd0 : cnt + 3'd1;
                state_n = !last_data ? DATA : (PARITY != 0 ? PARITY_BIT : STOP);
            end
            PARITY_BIT: if (bit_done) state_n = STOP;
            STOP: if (bit_done) begin
                cnt_n   = cnt + 3'd1;
                state_n = last_stop ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
        if (start_ok && (state == IDLE || (state == STOP && bit_done && last_stop))) begin
            pop     = 1'b1;
            state_n = START;
            timer_n = '0;
            cnt_n   = '0;
            sh_n    = head;
            par_n   = (^head) ^ (PARITY == 2);
        end
        line_n = state_n == START ? 1'b0 :
                 state_n == DATA ? sh_n[0] :
                 state_n == PARITY_BIT ? par_n : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO limits, reset abort and enable gating
module tb_uart_tx_fifo;
    localparam int CPB = 625;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] dat;
    logic [4:0] vld, en, rdy, ser, bsy;
    logic [4:0] c0, c1, c2, c3;
    logic [2:0] c4;
    int         sel;
    logic       line, busy_m, ready_m;
    int         count_m;
    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    always #5 clock = ~clock;

    uart_tx_fifo u0 (.clock(clock), .reset(reset), .tx_data(dat), .tx_valid(vld[0]), .tx_ready(rdy[0]),
                     .tx_enable(en[0]), .serial_tx(ser[0]), .busy(bsy[0]), .fifo_count(c0));
    uart_tx_fifo #(.PARITY(1)) u1 (.clock(clock), .reset(reset), .tx_data(dat), .tx_valid(vld[1]), .tx_ready(rdy[1]),
                     .tx_enable(en[1]), .serial_tx(ser[1]), .busy(bsy[1]), .fifo_count(c1));
    uart_tx_fifo #(.PARITY(2)) u2 (.clock(clock), .reset(reset), .tx_data(dat), .tx_valid(vld[2]), .tx_ready(rdy[2]),
                     .tx_enable(en[2]), .serial_tx(ser[2]), .busy(bsy[2]), .fifo_count(c2));
    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.clock(clock), .reset(reset), .tx_data(dat[6:0]), .tx_valid(vld[3]),
                     .tx_ready(rdy[3]), .tx_enable(en[3]), .serial_tx(ser[3]), .busy(bsy[3]), .fifo_count(c3));
    uart_tx_fifo #(.FIFO_DEPTH(4)) u4 (.clock(clock), .reset(reset), .tx_data(dat), .tx_valid(vld[4]), .tx_ready(rdy[4]),
                     .tx_enable(en[4]), .serial_tx(ser[4]), .busy(bsy[4]), .fifo_count(c4));

    always_comb begin
        line    = ser[sel];
        busy_m  = bsy[sel];
        ready_m = rdy[sel];
        case (sel)
            0: count_m = int'(c0);
            1: count_m = int'(c1);
            2: count_m = int'(c2);
            3: count_m = int'(c3);
            default: count_m = int'(c4);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        dat = d;
        vld[sel] = 1'b1;
        @(negedge clock);
        vld[sel] = 1'b0;
    endtask

    task automatic frame(input string tag, input int n, input logic [15:0] bits, input bit wait_first);
        int t = 0;
        if (wait_first)
            while (line !== 1'b0 && t < 4 * CPB) begin
                @(negedge clock);
                t++;
            end
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_b%0d_first", tag, k), 32'(line), 32'(bits[k]));
            repeat (CPB - 1) @(negedge clock);
            check($sformatf("%s_b%0d_last", tag, k), 32'(line), 32'(bits[k]));
            @(negedge clock);
        end
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        vld = '0;
        en = '0;
        dat = '0;
        sel = 0;
        repeat (3) @(negedge clock);
        check("rst_line", 32'(line), 1);
        check("rst_busy", 32'(busy_m), 0);
        check("rst_count", 32'(count_m), 0);
        check("rst_ready", 32'(ready_m), 1);
        reset = 1'b0;
        @(negedge clock);

        en[0] = 1'b1;
        dat = 8'h55;
        vld[0] = 1'b1;
        @(negedge clock);
        vld[0] = 1'b0;
        check("lat_idle_line", 32'(line), 1);
        check("lat_count1", 32'(count_m), 1);
        @(negedge clock);
        check("lat_start_line", 32'(line), 0);
        check("lat_busy", 32'(busy_m), 1);
        check("lat_count0", 32'(count_m), 0);
        frame("f55", 10, {6'b0, 1'b1, 8'h55, 1'b0}, 1'b0);
        check("f55_busy_end", 32'(busy_m), 0);
        check("f55_line_end", 32'(line), 1);

        sel = 1;
        en[1] = 1'b1;
        push(8'h07);
        frame("even07", 11, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 1'b1);
        check("even_busy_end", 32'(busy_m), 0);

        sel = 2;
        en[2] = 1'b1;
        push(8'h07);
        frame("odd07", 11, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 1'b1);
        check("odd_busy_end", 32'(busy_m), 0);

        sel = 3;
        en[3] = 1'b1;
        push(8'h41);
        frame("f7e2", 10, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 1'b1);
        check("f7e2_busy_end", 32'(busy_m), 0);

        sel = 4;
        vld[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dat = w[i];
            @(negedge clock);
        end
        check("full_count", 32'(count_m), 4);
        check("full_ready", 32'(ready_m), 0);
        vld[4] = 1'b0;
        repeat (20) @(negedge clock);
        check("full_hold_count", 32'(count_m), 4);
        check("full_hold_busy", 32'(busy_m), 0);
        en[4] = 1'b1;
        frame("q0", 10, {6'b0, 1'b1, w[0], 1'b0}, 1'b1);
        frame("q1", 10, {6'b0, 1'b1, w[1], 1'b0}, 1'b0);
        frame("q2", 10, {6'b0, 1'b1, w[2], 1'b0}, 1'b0);
        frame("q3", 10, {6'b0, 1'b1, w[3], 1'b0}, 1'b0);
        check("q_busy_end", 32'(busy_m), 0);
        check("q_count_end", 32'(count_m), 0);
        check("q_line_end", 32'(line), 1);

        sel = 0;
        dat = 8'hA1;
        vld[0] = 1'b1;
        @(negedge clock);
        dat = 8'hB2;
        @(negedge clock);
        dat = 8'hC3;
        @(negedge clock);
        vld[0] = 1'b0;
        repeat (4 * CPB + 300 - 1) @(negedge clock);
        check("abort_pre_count", 32'(count_m), 2);
        check("abort_pre_busy", 32'(busy_m), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_line", 32'(line), 1);
        check("abort_busy", 32'(busy_m), 0);
        check("abort_count", 32'(count_m), 0);
        check("abort_ready", 32'(ready_m), 1);
        bad = 0;
        repeat (4000) begin
            @(negedge clock);
            if (line !== 1'b1 || busy_m !== 1'b0) bad++;
        end
        check("abort_quiet", 32'(bad), 0);

        dat = 8'h0F;
        vld[0] = 1'b1;
        @(negedge clock);
        dat = 8'hA3;
        @(negedge clock);
        vld[0] = 1'b0;
        fork
            frame("en0F", 10, {6'b0, 1'b1, 8'h0F, 1'b0}, 1'b1);
            begin
                repeat (1500) @(negedge clock);
                en[0] = 1'b0;
            end
        join
        check("en_off_busy", 32'(busy_m), 0);
        check("en_off_count", 32'(count_m), 1);
        check("en_off_line", 32'(line), 1);
        repeat (1000) @(negedge clock);
        check("en_hold_busy", 32'(busy_m), 0);
        check("en_hold_count", 32'(count_m), 1);
        en[0] = 1'b1;
        frame("enA3", 10, {6'b0, 1'b1, 8'hA3, 1'b0}, 1'b1);
        check("en_final_busy", 32'(busy_m), 0);
        check("en_final_count", 32'(count_m), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 6000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate in bits/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries, power of 2, minimum 2.
REQ-007 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-008 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port: tx_data  input  DATA_BITS  word to enqueue.
REQ-010 SHALL have port: tx_valid  input  1  producer has a word on tx_data.
REQ-011 SHALL have port: tx_ready  output  1  FIFO can accept a word (not full).
REQ-012 SHALL have port: tx_enable  input  1  permits new frames to start.
REQ-013 SHALL have port: serial_tx  output  1  UART line, idle high, registered.
REQ-014 SHALL have port: busy  output  1  a frame is in progress (state != IDLE).
REQ-015 SHALL have port: fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued.

Function
REQ-016 SHALL compute CYCLES_PER_BIT = (CLOCK_HZ + BAUD/2) / BAUD at elaboration: 625 at defaults.
REQ-017 SHALL raise an elaboration error for illegal DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH, or CYCLES_PER_BIT < 2.
REQ-018 SHALL accept a word on a rising edge where tx_valid && tx_ready; no word is accepted when tx_ready is low.
REQ-019 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH), so tx_ready is low when full even if a pop occurs in the same cycle.
REQ-020 SHALL leave fifo_count unchanged on a simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-022 SHALL, in IDLE with fifo_count>0 and tx_enable=1, pop the head word and enter START on that edge.
REQ-023 SHALL reset a per-bit timer to 0 on frame start and hold each line bit exactly CYCLES_PER_BIT cycles; the timer does not free-run.
REQ-024 SHALL drive the frame as: start bit 0, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits of 1.
REQ-025 SHALL compute the parity bit as XOR of the data bits for even parity and its inverse for odd parity.
REQ-026 SHALL, at the end of the final stop bit, pop the next word and enter START on the same edge if fifo_count>0 and tx_enable=1, giving zero idle bits between frames; otherwise enter IDLE.
REQ-027 SHALL complete an in-progress frame if tx_enable falls mid-frame; tx_enable only gates frame starts.
REQ-028 SHALL drive serial_tx low on the cycle after the edge where a word is pushed into an empty FIFO while IDLE with tx_enable=1, i.e. 1-cycle start latency after acceptance.
REQ-029 SHALL hold serial_tx at 1 throughout IDLE.

Reset
REQ-030 SHALL, on reset, set serial_tx=1, busy=0, fifo_count=0, tx_ready=1, state IDLE, timer 0.
REQ-031 SHALL, on reset asserted mid-frame, abort the frame and discard all queued words; serial_tx=1 from the next cycle.
REQ-032 SHALL give reset priority over push and pop in the same cycle.

Verification
REQ-033 SHALL verify: defaults, push 0x55 into an idle FIFO -> serial_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 625 cycles, frame 6250 cycles, then busy=0.
REQ-034 SHALL verify: PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; both placed after bit 7 and before stop.
REQ-035 SHALL verify: DATA_BITS=7, STOP_BITS=2, word 0x41 -> start, 1,0,0,0,0,0,1, stop, stop; frame 10 bit-times.
REQ-036 SHALL verify: FIFO_DEPTH=4, tx_enable=0, offer 5 words -> 4 accepted, fifo_count=4, tx_ready=0, 5th held; raising tx_enable -> 4 frames with no idle gap, 40x625 cycles total.
REQ-037 SHALL verify: reset during data bit 3 with 2 words queued -> serial_tx=1, busy=0, fifo_count=0, tx_ready=1 the next cycle, and no further frames are sent.
REQ-038 SHALL verify: tx_enable dropped mid-frame with 1 word queued -> current frame completes, then IDLE with fifo_count=1 until tx_enable returns.
